// File: rtl/simon_pkg.sv
// Shared constants, FSM state encoding and small helpers for the Simon autoplayer.
//   MAX_GAME_LEN    - depth of the recorded-sequence memory
//   START_PRESS_MS  - length of the start-button press
//   LISTEN_GAP_MS   - silent LED time that ends a playback
//   ECHO_TIMEOUT_MS - longest wait for the game to echo a press
package simon_pkg;

  localparam int MAX_GAME_LEN    = 32;
  localparam int START_PRESS_MS  = 20;
  localparam int LISTEN_GAP_MS   = 250;
  localparam int ECHO_TIMEOUT_MS = 100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_PRESS,
    S_LISTEN,
    S_PRESS,
    S_WAIT_OFF,
    S_HALT
  } state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  // Encode a one-hot LED pattern to its index; only called on one-hot values.
  function automatic logic [1:0] enc4(input logic [3:0] v);
    logic [1:0] r;
    case (v)
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/milli_tick.sv
// Millisecond strobe generator.
//   clk, rst         - clock, synchronous active-high reset
//   ticks_per_milli  - clk cycles per millisecond minus one
//   ms_tick          - one-cycle pulse every ticks_per_milli+1 cycles
module milli_tick (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ticks_per_milli,
  output logic        ms_tick
);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      ms_tick <= 1'b0;
    end else if (cnt == ticks_per_milli) begin
      cnt     <= '0;
      ms_tick <= 1'b1;
    end else begin
      cnt     <= cnt + 16'd1;
      ms_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/simon_autoplayer.sv
// Simon autoplayer: presses start, records the game's LED playback, then
// replays it on the buttons, waiting for each echo before the next press.
//   clk, rst          - clock, synchronous active-high reset
//   ticks_per_milli   - clk cycles per ms minus one
//   enable            - autoplay on
//   miss_req          - make the next press deliberately wrong
//   led               - game LEDs (observed)
//   btn               - button drive, one-hot or zero
//   level             - length of the last fully recorded sequence
//   busy/game_over/error - active, game-over seen, echo timeout
module simon_autoplayer
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ticks_per_milli,
  input  logic        enable,
  input  logic        miss_req,
  input  logic [3:0]  led,
  output logic [3:0]  btn,
  output logic [5:0]  level,
  output logic        busy,
  output logic        game_over,
  output logic        error
);

  logic ms_tick;

  milli_tick u_milli_tick (
    .clk             (clk),
    .rst             (rst),
    .ticks_per_milli (ticks_per_milli),
    .ms_tick         (ms_tick)
  );

  state_t      state;
  logic [5:0]  count;
  logic [5:0]  idx;
  logic [7:0]  ms_cnt;
  logic [3:0]  led_prev;
  logic [3:0]  target;
  logic        miss_pend;
  logic [1:0]  seq [MAX_GAME_LEN];

  logic        rec;
  logic        miss_eff;
  logic [5:0]  nidx;
  logic [4:0]  rd_sel;
  logic [1:0]  seq_rd;
  logic [3:0]  press_btn;

  always_comb begin
    // Record only on a rising edge out of all-dark into a single LED.
    rec       = (state == S_LISTEN) && (led_prev == 4'b0000) && $onehot(led) &&
                (count < 6'(MAX_GAME_LEN));
    // A miss request stays pending until a press consumes it.
    miss_eff  = miss_pend | miss_req;
    nidx      = idx + 6'd1;
    // Entry from LISTEN always starts at seq[0]; from WAIT_OFF at the next index.
    rd_sel    = (state == S_WAIT_OFF) ? nidx[4:0] : 5'd0;
    seq_rd    = seq[rd_sel];
    press_btn = onehot4(seq_rd + {1'b0, miss_eff});
  end

  always_ff @(posedge clk) begin
    if (rec) seq[count[4:0]] <= enc4(led);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      btn       <= 4'b0000;
      level     <= '0;
      busy      <= 1'b0;
      game_over <= 1'b0;
      error     <= 1'b0;
      count     <= '0;
      idx       <= '0;
      ms_cnt    <= '0;
      led_prev  <= 4'b0000;
      target    <= 4'b0000;
      miss_pend <= 1'b0;
    end else begin
      led_prev <= led;
      if (miss_req) miss_pend <= 1'b1;

      if (!enable) begin
        state     <= S_IDLE;
        btn       <= 4'b0000;
        busy      <= 1'b0;
        miss_pend <= 1'b0;
        if (state != S_IDLE && led == 4'b1111) game_over <= 1'b1;
      end else if (state != S_IDLE && led == 4'b1111) begin
        state     <= S_HALT;
        btn       <= 4'b0000;
        busy      <= 1'b1;
        game_over <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            state     <= S_START_PRESS;
            btn       <= 4'b0001;
            busy      <= 1'b1;
            game_over <= 1'b0;
            error     <= 1'b0;
            ms_cnt    <= '0;
          end

          S_START_PRESS: begin
            if (ms_tick) begin
              if (ms_cnt == 8'(START_PRESS_MS - 1)) begin
                btn    <= 4'b0000;
                count  <= '0;
                ms_cnt <= '0;
                state  <= S_LISTEN;
              end else begin
                ms_cnt <= ms_cnt + 8'd1;
              end
            end
          end

          S_LISTEN: begin
            if (rec) count <= count + 6'd1;
            if (led != 4'b0000) begin
              ms_cnt <= '0;
            end else if (ms_tick) begin
              if (ms_cnt == 8'(LISTEN_GAP_MS - 1)) begin
                // Timer parks at the limit until something has been recorded.
                if (count != 6'd0) begin
                  level     <= count;
                  idx       <= '0;
                  btn       <= press_btn;
                  target    <= press_btn;
                  ms_cnt    <= '0;
                  miss_pend <= 1'b0;
                  state     <= S_PRESS;
                end
              end else begin
                ms_cnt <= ms_cnt + 8'd1;
              end
            end
          end

          S_PRESS: begin
            if (led == target) begin
              btn   <= 4'b0000;
              state <= S_WAIT_OFF;
            end else if (ms_tick) begin
              if (ms_cnt == 8'(ECHO_TIMEOUT_MS - 1)) begin
                btn   <= 4'b0000;
                error <= 1'b1;
                state <= S_HALT;
              end else begin
                ms_cnt <= ms_cnt + 8'd1;
              end
            end
          end

          S_WAIT_OFF: begin
            if (led == 4'b0000) begin
              idx <= nidx;
              if (nidx == level) begin
                count  <= '0;
                ms_cnt <= '0;
                state  <= S_LISTEN;
              end else begin
                btn       <= press_btn;
                target    <= press_btn;
                ms_cnt    <= '0;
                miss_pend <= 1'b0;
                state     <= S_PRESS;
              end
            end
          end

          S_HALT: btn <= 4'b0000;

          default: begin
            state <= S_IDLE;
            btn   <= 4'b0000;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simon_autoplayer.sv
// Directed bench for simon_autoplayer: the bench plays the game side
// (LED playback and button echo) with ticks_per_milli=9, i.e. 10 cycles/ms.
module tb_simon_autoplayer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ticks_per_milli;
  logic        enable;
  logic        miss_req;
  logic [3:0]  led;
  logic [3:0]  btn;
  logic [5:0]  level;
  logic        busy;
  logic        game_over;
  logic        error;

  int total = 0;
  int bad   = 0;
  int pat [40];

  always #5 clk = ~clk;

  simon_autoplayer dut (
    .clk             (clk),
    .rst             (rst),
    .ticks_per_milli (ticks_per_milli),
    .enable          (enable),
    .miss_req        (miss_req),
    .led             (led),
    .btn             (btn),
    .level           (level),
    .busy            (busy),
    .game_over       (game_over),
    .error           (error)
  );

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one = 4'b0001;
    return one << (i % 4);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flash(input logic [3:0] v, input int on_c, input int off_c);
    led = v;
    tick(on_c);
    led = 4'b0000;
    tick(off_c);
  endtask

  task automatic wait_btn(input int limit, output logic [3:0] b, output bit ok, output int waited);
    ok = 1'b0;
    b = 4'b0000;
    waited = 0;
    while (waited < limit && !ok) begin
      @(negedge clk);
      waited++;
      if (btn != 4'b0000) begin
        ok = 1'b1;
        b = btn;
      end
    end
  endtask

  // Game echo of a press: light the pressed LED briefly, then go dark.
  task automatic echo(input logic [3:0] b);
    tick(3);
    led = b;
    tick(20);
    led = 4'b0000;
  endtask

  // Toggle enable and let the start press finish; ok=0 if either bound expires.
  task automatic restart(output bit ok);
    logic [3:0] b;
    int w;
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    wait_btn(20, b, ok, w);
    if (ok) begin
      w = 0;
      while (btn != 4'b0000 && w < 300) begin
        @(negedge clk);
        w++;
      end
      if (btn != 4'b0000) ok = 1'b0;
    end
  endtask

  // One round: play pat[0..n-1], answer each press with an echo.
  // nbad counts missing or wrong presses.
  task automatic run_level(input int n, output int nbad);
    logic [3:0] b;
    bit ok;
    int w;
    nbad = 0;
    tick(100);
    for (int i = 0; i < n; i++) flash(oh(pat[i]), 50, 50);
    for (int i = 0; i < n; i++) begin
      wait_btn(3000, b, ok, w);
      if (!ok || b != oh(pat[i])) nbad++;
      if (ok) echo(b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; miss_req = 1'b0; led = 4'b0000; ticks_per_milli = 16'd9;
    tick(3);
    total++; if (btn !== 4'b0000) begin bad++; $display("FAIL reset_btn got=%b want=0000", btn); end
    total++; if (level !== 6'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL reset_game_over got=%b want=0", game_over); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", error); end
    rst = 1'b0;
    tick(3);
    total++; if (busy !== 1'b0 || btn !== 4'b0000) begin bad++; $display("FAIL idle_outputs got busy=%b btn=%b want busy=0 btn=0000", busy, btn); end
  endtask

  task automatic test_start_pulse();
    logic [3:0] b;
    bit ok;
    int w, len;
    enable = 1'b1;
    wait_btn(20, b, ok, w);
    total++; if (!ok || b !== 4'b0001) begin bad++; $display("FAIL start_btn got=%b want=0001", b); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%b want=1", busy); end
    len = 0;
    while (btn == 4'b0001 && len < 400) begin @(negedge clk); len++; end
    total++; if (len < 185 || len > 205) begin bad++; $display("FAIL start_len got=%0d want=185..205 cycles", len); end
    total++; if (btn !== 4'b0000) begin bad++; $display("FAIL start_release got=%b want=0000", btn); end
  endtask

  task automatic test_level5();
    int nb;
    pat[0] = 2; pat[1] = 0; pat[2] = 3; pat[3] = 1; pat[4] = 2;
    for (int n = 1; n <= 5; n++) begin
      run_level(n, nb);
      total++; if (nb !== 0) begin bad++; $display("FAIL level%0d_presses got=%0d wrong want=0", n, nb); end
      total++; if (level !== 6'(n)) begin bad++; $display("FAIL level%0d_value got=%0d want=%0d", n, level, n); end
    end
    total++; if (game_over !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL level5_flags got go=%b err=%b want 0 0", game_over, error); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL level5_busy got=%b want=1", busy); end
  endtask

  task automatic test_miss();
    logic [3:0] b;
    bit ok, pressed;
    int nb, w;
    pat[0] = 2; pat[1] = 1; pat[2] = 0;
    restart(ok);
    total++; if (!ok) begin bad++; $display("FAIL miss_restart got=timeout want=start press"); end
    run_level(1, nb);
    run_level(2, w);
    total++; if (nb + w !== 0) begin bad++; $display("FAIL miss_pre_levels got=%0d wrong want=0", nb + w); end
    tick(100);
    flash(oh(pat[0]), 50, 10);
    miss_req = 1'b1; tick(1); miss_req = 1'b0;
    tick(39);
    flash(oh(pat[1]), 50, 50);
    flash(oh(pat[2]), 50, 50);
    wait_btn(3000, b, ok, w);
    total++; if (!ok || b !== 4'b1000) begin bad++; $display("FAIL miss_wrong_btn got=%b want=1000", b); end
    tick(3);
    led = 4'b1111;
    tick(2);
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL miss_game_over got=%b want=1", game_over); end
    total++; if (btn !== 4'b0000 || busy !== 1'b1) begin bad++; $display("FAIL miss_halt got btn=%b busy=%b want 0000 1", btn, busy); end
    total++; if (level !== 6'd3) begin bad++; $display("FAIL miss_level got=%0d want=3", level); end
    led = 4'b0000;
    pressed = 1'b0;
    for (int i = 0; i < 3000; i++) begin @(negedge clk); if (btn != 4'b0000) pressed = 1'b1; end
    total++; if (pressed !== 1'b0 || game_over !== 1'b1) begin bad++; $display("FAIL miss_stays_halted got pressed=%b go=%b want 0 1", pressed, game_over); end
  endtask

  task automatic test_timeout();
    logic [3:0] b;
    bit ok;
    int w, len;
    restart(ok);
    total++; if (!ok) begin bad++; $display("FAIL to_restart got=timeout want=start press"); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL to_go_cleared got=%b want=0", game_over); end
    tick(100);
    flash(4'b0100, 50, 50);
    wait_btn(3000, b, ok, w);
    total++; if (!ok || b !== 4'b0100) begin bad++; $display("FAIL to_press got=%b want=0100", b); end
    len = 0;
    while (btn != 4'b0000 && len < 1200) begin @(negedge clk); len++; end
    total++; if (len < 985 || len > 1005) begin bad++; $display("FAIL to_len got=%0d want=985..1005 cycles", len); end
    total++; if (error !== 1'b1 || game_over !== 1'b0) begin bad++; $display("FAIL to_flags got err=%b go=%b want 1 0", error, game_over); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL to_busy got=%b want=1", busy); end
    enable = 1'b0;
    tick(1);
    total++; if (busy !== 1'b0 || error !== 1'b1) begin bad++; $display("FAIL to_disable got busy=%b err=%b want 0 1", busy, error); end
  endtask

  task automatic test_enable_and_reset();
    logic [3:0] b;
    bit ok;
    int w;
    restart(ok);
    total++; if (!ok || error !== 1'b0) begin bad++; $display("FAIL en_restart got ok=%b err=%b want 1 0", ok, error); end
    tick(100);
    flash(4'b0010, 50, 50);
    wait_btn(3000, b, ok, w);
    total++; if (!ok || b !== 4'b0010) begin bad++; $display("FAIL en_press got=%b want=0010", b); end
    enable = 1'b0;
    tick(1);
    total++; if (btn !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL en_drop got btn=%b busy=%b want 0000 0", btn, busy); end
    restart(ok);
    flash(4'b1000, 50, 20);
    total++; if (!ok || busy !== 1'b1 || level !== 6'd1) begin bad++; $display("FAIL rst_pre got ok=%b busy=%b level=%0d want 1 1 1", ok, busy, level); end
    rst = 1'b1;
    tick(1);
    total++; if (btn !== 4'b0000 || level !== 6'd0 || busy !== 1'b0 || game_over !== 1'b0 || error !== 1'b0) begin
      bad++; $display("FAIL rst_listen got btn=%b level=%0d busy=%b go=%b err=%b want all 0", btn, level, busy, game_over, error);
    end
    rst = 1'b0;
    enable = 1'b0;
    tick(2);
  endtask

  task automatic test_gaps();
    logic [3:0] b;
    bit ok, early;
    int w;
    restart(ok);
    total++; if (!ok) begin bad++; $display("FAIL gap_restart got=timeout want=start press"); end
    tick(100);
    early = 1'b0;
    led = 4'b1000; tick(50); led = 4'b0000;
    for (int i = 0; i < 1000; i++) begin @(negedge clk); if (btn != 4'b0000) early = 1'b1; end
    led = 4'b0001; tick(50); led = 4'b0000;
    for (int i = 0; i < 1000; i++) begin @(negedge clk); if (btn != 4'b0000) early = 1'b1; end
    flash(4'b0100, 50, 50);
    total++; if (early !== 1'b0) begin bad++; $display("FAIL gap_premature got=press want=none"); end
    wait_btn(3000, b, ok, w);
    total++; if (!ok || b !== 4'b1000) begin bad++; $display("FAIL gap_first got=%b want=1000", b); end
    total++; if (w < 2400 || w > 2500) begin bad++; $display("FAIL gap_delay got=%0d want=2400..2500 cycles", w); end
    total++; if (level !== 6'd3) begin bad++; $display("FAIL gap_level got=%0d want=3", level); end
    if (ok) echo(b);
    enable = 1'b0;
    tick(2);
  endtask

  task automatic test_len33();
    logic [3:0] b;
    bit ok;
    int w, presses, wrong, extra;
    for (int i = 0; i < 33; i++) pat[i] = (i * 3 + i / 4) % 4;
    restart(ok);
    total++; if (!ok) begin bad++; $display("FAIL l33_restart got=timeout want=start press"); end
    tick(100);
    for (int i = 0; i < 33; i++) flash(oh(pat[i]), 30, 30);
    presses = 0;
    wrong = 0;
    for (int i = 0; i < 32; i++) begin
      wait_btn(3000, b, ok, w);
      if (ok) begin
        presses++;
        if (b != oh(pat[i])) wrong++;
        echo(b);
      end
    end
    total++; if (level !== 6'd32) begin bad++; $display("FAIL l33_level got=%0d want=32", level); end
    total++; if (presses !== 32) begin bad++; $display("FAIL l33_presses got=%0d want=32", presses); end
    total++; if (wrong !== 0) begin bad++; $display("FAIL l33_wrong got=%0d want=0", wrong); end
    extra = 0;
    for (int i = 0; i < 3500; i++) begin
      @(negedge clk);
      if (btn != 4'b0000) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL l33_extra got=%0d cycles pressed want=0", extra); end
  endtask

  initial begin
    test_reset();
    test_start_pulse();
    test_level5();
    test_miss();
    test_timeout();
    test_enable_and_reset();
    test_gaps();
    test_len33();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
